alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for one shared `ALU32Bit` instance. It accepts operand/opcode requests from two independent clients over valid/ready handshakes and picks a winner by round-robin. It drives the winning operands through the ALU from registered inputs, then returns the registered result and zero flag to the granted client over a per-client response handshake. It sits between the instruction-issue logic and the 32-bit ALU, so a single ALU can serve both the main datapath and an auxiliary client such as an address or compare unit.

---
 rtl/alu_arbiter_if.sv | 18 +
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Per-client request/response channel into the shared ALU arbiter.
// The client drives the master side; the arbiter takes the slave side.
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  modport master (output req_valid, req_a, req_b, req_op, rsp_ready,
                  input  req_ready, rsp_valid, rsp_result, rsp_zero);
  modport slave  (input  req_valid, req_a, req_b, req_op, rsp_ready,
                  output req_ready, rsp_valid, rsp_result, rsp_zero);
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-client front end for one shared 32-bit ALU.
// Each accepted request runs through the ALU from registered operands and is answered on its own channel.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  c0,
  alu_arbiter_if.slave  c1,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             zero_q, zero_d;

  logic             gnt0, gnt1, owner_rsp_ready;
  logic [WIDTH-1:0] bb, sum, alu_res;
  logic             ovf;

  // ALU32Bit behaviour: bit 2 inverts b and supplies the carry-in, so SUB/SLT share the adder.
  always_comb begin
    bb  = op_q[2] ? ~b_q : b_q;
    sum = a_q + bb + {{(WIDTH-1){1'b0}}, op_q[2]};
    ovf = (a_q[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    case (op_q[1:0])
      2'b00:   alu_res = a_q & bb;
      2'b01:   alu_res = a_q | bb;
      2'b10:   alu_res = sum;
      default: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
    endcase
  end

  // On a tie the client that did not win last time gets the grant.
  always_comb begin
    gnt0 = c0.req_valid & (~c1.req_valid | last_q);
    gnt1 = c1.req_valid & (~c0.req_valid | ~last_q);
    owner_rsp_ready = owner_q ? c1.rsp_ready : c0.rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (gnt0 | gnt1) begin
        owner_d = gnt1;
        last_d  = gnt1;
        a_d     = gnt1 ? c1.req_a  : c0.req_a;
        b_d     = gnt1 ? c1.req_b  : c0.req_b;
        op_d    = gnt1 ? c1.req_op : c0.req_op;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_res;
        zero_d  = (alu_res == '0);
        state_d = RESP;
      end
      RESP: if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    c0.req_ready  = rst_n & (state_q == IDLE) & gnt0;
    c1.req_ready  = rst_n & (state_q == IDLE) & gnt1;
    c0.rsp_valid  = (state_q == RESP) & ~owner_q;
    c1.rsp_valid  = (state_q == RESP) &  owner_q;
    c0.rsp_result = res_q;
    c1.rsp_result = res_q;
    c0.rsp_zero   = zero_q;
    c1.rsp_zero   = zero_q;
    busy          = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  alu_arbiter_if #(.WIDTH(32)) i0 ();
  alu_arbiter_if #(.WIDTH(32)) i1 ();

  alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .c0(i0), .c1(i1), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int m_last = 1;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hx;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk += 1;
    assert (obs === exp) n_pass += 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rv0"}, i0.rsp_valid, 0);
    chk({tag, "_rv1"}, i1.rsp_valid, 0);
  endtask

  // One full transaction starting at a negedge in IDLE; stall = cycles the owner withholds rsp_ready.
  task automatic txn(input bit v0, input bit v1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                     input int stall);
    int w;
    logic [31:0] er;
    i0.req_valid = v0; i0.req_a = a0; i0.req_b = b0; i0.req_op = op0;
    i1.req_valid = v1; i1.req_a = a1; i1.req_b = b1; i1.req_op = op1;
    #1;
    w  = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
    er = (w == 0) ? ref_alu(a0, b0, op0) : ref_alu(a1, b1, op1);
    chk("idle_ready0", i0.req_ready, w == 0);
    chk("idle_ready1", i1.req_ready, w == 1);
    chk_quiet("idle");
    @(negedge clk);
    m_last = w;
    // Disturb the winner's operands to show the ALU runs from captured copies.
    if (w == 0) begin i0.req_valid = 0; i0.req_a = ~a0; end
    else        begin i1.req_valid = 0; i1.req_a = ~a1; end
    chk("exec_busy", busy, 1);
    chk("exec_rv0", i0.rsp_valid, 0);
    chk("exec_rv1", i1.rsp_valid, 0);
    chk("exec_ready0", i0.req_ready, 0);
    chk("exec_ready1", i1.req_ready, 0);
    @(negedge clk);
    for (int k = 0; k <= stall; k++) begin
      chk("resp_rv_owner", (w == 0) ? i0.rsp_valid : i1.rsp_valid, 1);
      chk("resp_rv_other", (w == 0) ? i1.rsp_valid : i0.rsp_valid, 0);
      chk("resp_result", (w == 0) ? i0.rsp_result : i1.rsp_result, er);
      chk("resp_zero", (w == 0) ? i0.rsp_zero : i1.rsp_zero, er == 0);
      chk("resp_busy", busy, 1);
      chk("resp_ready_other", (w == 0) ? i1.req_ready : i0.req_ready, 0);
      // The non-owner's rsp_ready is held high to show it is ignored.
      i0.rsp_ready = (w == 0) ? (k == stall) : 1'b1;
      i1.rsp_ready = (w == 1) ? (k == stall) : 1'b1;
      @(negedge clk);
    end
    i0.rsp_ready = 0;
    i1.rsp_ready = 0;
    chk_quiet("after_hs");
  endtask

  logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  function automatic logic [31:0] rnd_operand();
    int s = $urandom_range(0, 3);
    if (s == 0) return 32'hFFFF_FFFF;
    if (s == 1) return $urandom_range(0, 3);
    return $urandom;
  endfunction

  initial begin
    i0.req_valid = 0; i0.req_a = 0; i0.req_b = 0; i0.req_op = 0; i0.rsp_ready = 0;
    i1.req_valid = 0; i1.req_a = 0; i1.req_b = 0; i1.req_op = 0; i1.rsp_ready = 0;

    // Reset held with both clients requesting: nothing may be offered.
    i0.req_valid = 1; i1.req_valid = 1;
    #1;
    chk("rst_ready0", i0.req_ready, 0);
    chk("rst_ready1", i1.req_ready, 0);
    chk_quiet("rst");
    repeat (2) @(negedge clk);
    i0.req_valid = 0; i1.req_valid = 0;
    rst_n = 1;

    // Single ADD from client 0, then SUB-to-zero and signed SLT from client 1.
    txn(1, 0, 5, 3, 3'b010, 0, 0, 0, 0);
    txn(0, 1, 0, 0, 0, 7, 7, 3'b110, 0);
    txn(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 1, 3'b111, 1);

    // Client drops its request before any edge sees it.
    i1.req_valid = 1; i1.req_a = 1; i1.req_b = 1; i1.req_op = 3'b010;
    #1;
    chk("drop_ready1", i1.req_ready, 1);
    #2;
    i1.req_valid = 0;
    @(negedge clk);
    chk_quiet("drop");

    // Continuous contention must alternate, each response carrying its own operands.
    repeat (6) txn(1, 1, 32'hF0F0, 32'hFF00, 3'b000, 32'h0F, 32'hF0, 3'b001, 0);

    // Owner backpressure for 5 cycles; client 1 is taken right after release.
    txn(1, 1, 32'h10, 32'h20, 3'b010, 32'h3, 32'h4, 3'b010, 5);
    txn(0, 1, 0, 0, 0, 32'h3, 32'h4, 3'b010, 0);

    // Asynchronous reset mid-EXEC drops the transaction.
    i0.req_valid = 1; i0.req_a = 9; i0.req_b = 9; i0.req_op = 3'b110;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    i1.req_valid = 1;
    #2 rst_n = 0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_ready0", i0.req_ready, 0);
    chk("async_rst_ready1", i1.req_ready, 0);
    repeat (2) begin
      @(negedge clk);
      chk_quiet("rst_hold");
    end
    rst_n = 1;
    m_last = 1;
    txn(1, 1, 32'hFFFF_FFFF, 1, 3'b010, 2, 2, 3'b010, 0);

    // Randomized mix checked against the model.
    for (int n = 0; n < 30; n++) begin
      bit rv0, rv1;
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1;
      txn(rv0, rv1,
          rnd_operand(), rnd_operand(), ops[$urandom_range(0, 4)],
          rnd_operand(), rnd_operand(), ops[$urandom_range(0, 4)],
          $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
